// File: rtl/collision_checker_pkg.sv
// Shared Tron definitions: screen/map geometry, arena defaults,
// FSM state encodings, coordinate bundle and map address helper.
package tron_defs;

  localparam int SCR_W     = 160;
  localparam int SCR_H     = 120;
  localparam int MAP_DEPTH = SCR_W * SCR_H;
  localparam int MAP_AW    = 15;

  localparam logic [MAP_AW-1:0] MAP_LAST = 15'd19199;

  localparam logic [7:0] SCR_X_LAST = 8'd159;
  localparam logic [6:0] SCR_Y_LAST = 7'd119;

  localparam logic [7:0] X_MIN_DEF = 8'd10;
  localparam logic [7:0] X_MAX_DEF = 8'd149;
  localparam logic [6:0] Y_MIN_DEF = 7'd17;
  localparam logic [6:0] Y_MAX_DEF = 7'd108;

  typedef enum logic [2:0] {
    ST_CLEAR = 3'd0,
    ST_IDLE  = 3'd1,
    ST_RD1   = 3'd2,
    ST_RD2   = 3'd3,
    ST_CHK   = 3'd4,
    ST_WR1   = 3'd5,
    ST_WR2   = 3'd6,
    ST_DONE  = 3'd7
  } state_e;

  typedef struct packed {
    logic [7:0] x;
    logic [6:0] y;
  } coord_t;

  // y*160 + x without a multiplier
  function automatic logic [MAP_AW-1:0] cell_addr(
    input coord_t c
  );
    logic [MAP_AW-1:0] yy;
    yy = {8'd0, c.y};
    return (yy << 7) + (yy << 5) + {7'd0, c.x};
  endfunction

  function automatic logic on_screen(
    input coord_t c
  );
    return (c.x <= SCR_X_LAST) && (c.y <= SCR_Y_LAST);
  endfunction

endpackage

// File: rtl/occ_ram.sv
// Trail occupancy map: single port 19200x1, sync write, registered read.
// Ports: clk_i, en_i, we_i, addr_i, wdata_i -> rdata_o (1-cycle latency).
module occ_ram
  import tron_defs::*;
(
  input  logic              clk_i,
  input  logic              en_i,
  input  logic              we_i,
  input  logic [MAP_AW-1:0] addr_i,
  input  logic              wdata_i,
  output logic              rdata_o
);

  logic mem [MAP_DEPTH];
  logic rdata_q;

  // Contents are deliberately not reset; the CLEAR sweep owns init.
  always_ff @(posedge clk_i) begin
    if (en_i && we_i) begin
      mem[addr_i] <= wdata_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (en_i && !we_i) begin
      rdata_q <= mem[addr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/collision_checker.sv
// Tron collision checker: per game tick reads both heads from the trail map,
// flags border/trail/head-on hits, then marks both heads. Ports: clk, resetn,
// clear, step, p1/p2 coords in; busy, done, dead1, dead2, game_over out.
module collision_checker
  import tron_defs::*;
#(
  parameter logic [7:0] ARENA_X_MIN = X_MIN_DEF,
  parameter logic [7:0] ARENA_X_MAX = X_MAX_DEF,
  parameter logic [6:0] ARENA_Y_MIN = Y_MIN_DEF,
  parameter logic [6:0] ARENA_Y_MAX = Y_MAX_DEF
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       clear,
  input  logic       step,
  input  logic [7:0] p1_x,
  input  logic [6:0] p1_y,
  input  logic [7:0] p2_x,
  input  logic [6:0] p2_y,
  output logic       busy,
  output logic       done,
  output logic       dead1,
  output logic       dead2,
  output logic       game_over
);

  state_e            state_q, state_d;
  logic [MAP_AW-1:0] sweep_q, sweep_d;
  coord_t            p1_q, p1_d;
  coord_t            p2_q, p2_d;
  logic              bit1_q, bit1_d;
  logic              dead1_q, dead1_d;
  logic              dead2_q, dead2_d;
  logic              done_q, done_d;

  logic              ram_en;
  logic              ram_we;
  logic              ram_wd;
  logic [MAP_AW-1:0] ram_addr;
  logic              ram_rd;

  logic [MAP_AW-1:0] a1, a2;
  logic              in1, in2;
  logic              brd1, brd2;
  logic              same;
  logic              hit1, hit2;

  assign a1  = cell_addr(p1_q);
  assign a2  = cell_addr(p2_q);
  assign in1 = on_screen(p1_q);
  assign in2 = on_screen(p2_q);

  assign brd1 = (p1_q.x <= ARENA_X_MIN)
              | (p1_q.x >= ARENA_X_MAX)
              | (p1_q.y <= ARENA_Y_MIN)
              | (p1_q.y >= ARENA_Y_MAX);
  assign brd2 = (p2_q.x <= ARENA_X_MIN)
              | (p2_q.x >= ARENA_X_MAX)
              | (p2_q.y <= ARENA_Y_MIN)
              | (p2_q.y >= ARENA_Y_MAX);

  assign same = (p1_q == p2_q);

  // Off-screen heads never touch the map, so their read data is masked.
  assign hit1 = bit1_q | ~in1 | brd1 | same;
  assign hit2 = (in2 & ram_rd) | ~in2 | brd2 | same;

  assign game_over = dead1_q | dead2_q;

  always_comb begin
    state_d  = state_q;
    sweep_d  = sweep_q;
    p1_d     = p1_q;
    p2_d     = p2_q;
    bit1_d   = bit1_q;
    dead1_d  = dead1_q;
    dead2_d  = dead2_q;
    done_d   = 1'b0;
    ram_en   = 1'b0;
    ram_we   = 1'b0;
    ram_wd   = 1'b0;
    ram_addr = sweep_q;
    if (clear) begin
      state_d = ST_CLEAR;
      sweep_d = '0;
      dead1_d = 1'b0;
      dead2_d = 1'b0;
    end else begin
      // done is registered, so it lands one edge after DONE
      done_d = (state_q == ST_DONE);
      case (state_q)
        ST_CLEAR: begin
          ram_en = 1'b1;
          ram_we = 1'b1;
          if (sweep_q == MAP_LAST) begin
            state_d = ST_IDLE;
          end else begin
            sweep_d = sweep_q + 1'b1;
          end
        end
        ST_IDLE: begin
          if (step && !game_over) begin
            p1_d    = '{x: p1_x, y: p1_y};
            p2_d    = '{x: p2_x, y: p2_y};
            state_d = ST_RD1;
          end
        end
        ST_RD1: begin
          ram_addr = a1;
          ram_en   = in1;
          state_d  = ST_RD2;
        end
        ST_RD2: begin
          bit1_d   = in1 & ram_rd;
          ram_addr = a2;
          ram_en   = in2;
          state_d  = ST_CHK;
        end
        ST_CHK: begin
          dead1_d = dead1_q | hit1;
          dead2_d = dead2_q | hit2;
          state_d = ST_WR1;
        end
        ST_WR1: begin
          ram_addr = a1;
          ram_en   = in1;
          ram_we   = 1'b1;
          ram_wd   = 1'b1;
          state_d  = ST_WR2;
        end
        ST_WR2: begin
          ram_addr = a2;
          ram_en   = in2;
          ram_we   = 1'b1;
          ram_wd   = 1'b1;
          state_d  = ST_DONE;
        end
        ST_DONE: begin
          state_d = ST_IDLE;
        end
        default: begin
          state_d = ST_CLEAR;
          sweep_d = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= ST_CLEAR;
      sweep_q <= '0;
      p1_q    <= '0;
      p2_q    <= '0;
      bit1_q  <= 1'b0;
      dead1_q <= 1'b0;
      dead2_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sweep_q <= sweep_d;
      p1_q    <= p1_d;
      p2_q    <= p2_d;
      bit1_q  <= bit1_d;
      dead1_q <= dead1_d;
      dead2_q <= dead2_d;
      done_q  <= done_d;
    end
  end

  occ_ram u_ram (
    .clk_i   (clk),
    .en_i    (ram_en),
    .we_i    (ram_we),
    .addr_i  (ram_addr),
    .wdata_i (ram_wd),
    .rdata_o (ram_rd)
  );

  assign busy  = (state_q != ST_IDLE);
  assign done  = done_q;
  assign dead1 = dead1_q;
  assign dead2 = dead2_q;

endmodule
